sqrt_stage: RTL and testbench

//  Square-root stage directly downstream of the divider. Takes a 20-bit unsigned Q10.10 quotient
//  and returns its square root as an unsigned Q5.10 value, held under a valid/ready handshake.

---
 rtl/sqrt_stage.sv | 143 ++++++++++++++
 tb/tb_sqrt_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_stage.sv
// Bit-serial restoring square root of an unsigned Q10.10 quotient, producing a Q5.10 result.
// Optional build macro SQRT_ROUND_EN adds a round-half-up step after the last result bit.
module sqrt_stage #(
    parameter int unsigned IN_W   = 20,
    parameter int unsigned FRAC_W = 10,
    parameter int unsigned OUT_W  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             drop
);

    localparam int unsigned R_W = IN_W + FRAC_W;
    localparam int unsigned K_W = $clog2(OUT_W);
    localparam logic [K_W-1:0] K_MSB = K_W'(OUT_W - 1);

`ifdef SQRT_ROUND_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2,
        ROUND = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [R_W-1:0]     r_q, r_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               out_valid_d;
    logic [OUT_W-1:0]   out_data_d;
    logic               drop_d;

    logic [OUT_W-1:0]   trial;
    logic [R_W-1:0]     trial_sq;

    assign in_ready = (state_q == IDLE);

    // Candidate with the current bit set; kept only if its square still fits under R.
    assign trial    = y_q | (OUT_W'(1) << k_q);
    assign trial_sq = R_W'(trial) * R_W'(trial);

`ifdef SQRT_ROUND_EN
    logic [R_W-1:0]     y_sq;
    logic [R_W-1:0]     rem;
    logic               round_up;

    // sqrt(R) >= Y + 0.5 reduces to R - Y*Y > Y for integer R; saturate at the top code.
    assign y_sq     = R_W'(y_q) * R_W'(y_q);
    assign rem      = r_q - y_sq;
    assign round_up = (rem > R_W'(y_q)) && (y_q != {OUT_W{1'b1}});
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        y_d         = y_q;
        k_d         = k_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        drop_d      = in_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = {in_data, {FRAC_W{1'b0}}};
                    y_d     = '0;
                    k_d     = K_MSB;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (trial_sq <= r_q) begin
                    y_d = trial;
                end
                if (k_q == '0) begin
`ifdef SQRT_ROUND_EN
                    state_d = ROUND;
`else
                    state_d = DONE;
`endif
                end else begin
                    k_d = k_q - K_W'(1);
                end
            end
`ifdef SQRT_ROUND_EN
            ROUND: begin
                if (round_up) begin
                    y_d = y_q + OUT_W'(1);
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                // First DONE cycle loads the output; a ready seen before valid is ignored.
                if (!out_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = y_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            y_q       <= '0;
            k_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            drop      <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            y_q       <= y_d;
            k_q       <= k_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            drop      <= drop_d;
        end
    end

endmodule

// File: tb/tb_sqrt_stage.sv
// Self-checking bench for sqrt_stage: directed vector table, handshake corner cases, random stream.
module tb_sqrt_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [14:0] out_data;
    logic        out_ready;
    logic        drop;

    int checks = 0;
    int errors = 0;

`ifdef SQRT_ROUND_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    sqrt_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] din;
        logic [14:0] exp_t;
        logic [14:0] exp_r;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one word for exactly one accept edge.
    task automatic send(input logic [19:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    function automatic logic [14:0] ref_sqrt(input logic [19:0] x);
        longint r;
        longint y;
        r = longint'(x) << 10;
        y = longint'($floor($sqrt(real'(r))));
        while (y * y > r) y = y - 1;
        while ((y + 1) * (y + 1) <= r) y = y + 1;
`ifdef SQRT_ROUND_EN
        if ((4 * y * y + 4 * y + 1 <= 4 * r) && (y < 32767)) y = y + 1;
`endif
        return 15'(y);
    endfunction

    function automatic logic [14:0] pick(input vec_t v);
`ifdef SQRT_ROUND_EN
        return v.exp_r;
`else
        return v.exp_t;
`endif
    endfunction

    initial begin
        int          n;
        int          drops;
        int          sent;
        int          got;
        int          cyc;
        int          exp_drops;
        int          act_drops;
        logic [19:0] cur;
        logic        ov;
        logic        ir;
        logic        orr;
        logic        acc;
        logic [14:0] od;
        logic [14:0] q[$];

        vecs[0] = '{20'h01000, 15'h0800, 15'h0800};
        vecs[1] = '{20'h00800, 15'h05A8, 15'h05A8};
        vecs[2] = '{20'h00005, 15'h0047, 15'h0048};
        vecs[3] = '{20'hFFFFF, 15'h7FFF, 15'h7FFF};
        vecs[4] = '{20'h00000, 15'h0000, 15'h0000};
        vecs[5] = '{20'h00001, 15'h0020, 15'h0020};
        vecs[6] = '{20'h00003, 15'h0037, 15'h0037};
        vecs[7] = '{20'h00190, 15'h0280, 15'h0280};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_drop", 32'(drop), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Directed vectors with out_ready tied high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].din);
            wait_out(n);
            chk($sformatf("vec%0d_latency", i), 32'(n), 32'(LAT));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(pick(vecs[i])));
            step();
            chk($sformatf("vec%0d_valid_cleared", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_ready_back", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result held for 10 cycles, two in_valid pulses dropped.
        out_ready = 1'b0;
        send(20'h00800);
        wait_out(n);
        chk("bp_latency", 32'(n), 32'(LAT));
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 2 || i == 5);
            in_data  = 20'h12345;
            step();
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
            chk("bp_out_data_held", 32'(out_data), 32'h05A8);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            drops += int'(drop);
        end
        in_valid = 1'b0;
        chk("bp_drop_pulses", 32'(drops), 32'd2);
        out_ready = 1'b1;
        step();
        chk("bp_transfer_valid", 32'(out_valid), 32'd0);
        chk("bp_transfer_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_no_extra_result", 32'(out_valid), 32'd0);
        end

        // Reset in the middle of CALC.
        send(20'h01000);
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("mid_drop_in_calc", 32'(drop), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_drop", 32'(drop), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_no_result", 32'(out_valid), 32'd0);
        send(20'h01000);
        wait_out(n);
        chk("post_rst_latency", 32'(n), 32'(LAT));
        chk("post_rst_data", 32'(out_data), 32'h0800);
        step();

        // Random stream: in_valid held high, random out_ready, in-order scoreboard.
        sent      = 0;
        got       = 0;
        cyc       = 0;
        exp_drops = 0;
        act_drops = 0;
        cur       = 20'($urandom_range(0, 32'hFFFFF));
        in_valid  = 1'b1;
        in_data   = cur;
        while ((sent < 100 || got < sent) && cyc < 20000) begin
            ov  = out_valid;
            od  = out_data;
            ir  = in_ready;
            orr = 1'($urandom_range(0, 1));
            out_ready = orr;
            acc = in_valid && ir;
            if (in_valid && !ir) exp_drops++;
            if (ov && orr) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_result", 32'(od), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("rand_result%0d", got), 32'(od), 32'(q.pop_front()));
                end
                got++;
            end
            if (acc) begin
                q.push_back(ref_sqrt(cur));
                sent++;
            end
            step();
            act_drops += int'(drop);
            cyc++;
            if (acc) begin
                if (sent < 100) begin
                    cur     = 20'($urandom_range(0, 32'hFFFFF));
                    in_data = cur;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("rand_results_count", 32'(got), 32'd100);
        chk("rand_drop_count", 32'(act_drops), 32'(exp_drops));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
